// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates committed stores, loads and fetches onto a byte-wide RAM/IO bus.
// Load/fetch result is ready N+2 cycles after acceptance; IO-full stalls write bytes, rdy low freezes all state.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_OP_WIDTH
`define INST_OP_WIDTH 6
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module mem_ctrl #(
    parameter logic [`XLEN-1:0] IO_ADDR = 32'h30000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       io_buffer_full,
    input  logic                       rob_mem_enable,
    input  logic [`INST_OP_WIDTH-1:0]  rob_mem_op,
    input  logic [`XLEN-1:0]           rob_mem_addr,
    input  logic [`XLEN-1:0]           rob_mem_val,
    input  logic                       lsb_load_enable,
    input  logic [`INST_OP_WIDTH-1:0]  lsb_load_op,
    input  logic [`XLEN-1:0]           lsb_load_addr,
    input  logic [`ROB_SIZE_WIDTH-1:0] lsb_load_id,
    input  logic                       if_enable,
    input  logic [`XLEN-1:0]           if_addr,
    input  logic [7:0]                 mem_din,
    output logic [7:0]                 mem_dout,
    output logic [`XLEN-1:0]           mem_a,
    output logic                       mem_wr,
    output logic                       mem_busy,
    output logic                       mem_data_ready,
    output logic [`XLEN-1:0]           mem_data,
    output logic [`ROB_SIZE_WIDTH-1:0] mem_id,
    output logic                       mem_inst_ready,
    output logic [31:0]                mem_inst
);
    localparam int XW  = `XLEN;
    localparam int OPW = `INST_OP_WIDTH;
    localparam int IDW = `ROB_SIZE_WIDTH;

    localparam logic [OPW-1:0] OP_LB  = OPW'(1);
    localparam logic [OPW-1:0] OP_LH  = OPW'(2);
    localparam logic [OPW-1:0] OP_LW  = OPW'(3);
    localparam logic [OPW-1:0] OP_LBU = OPW'(4);
    localparam logic [OPW-1:0] OP_LHU = OPW'(5);
    localparam logic [OPW-1:0] OP_SB  = OPW'(6);
    localparam logic [OPW-1:0] OP_SH  = OPW'(7);
    localparam logic [OPW-1:0] OP_SW  = OPW'(8);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [XW-1:0]  addr_q, addr_d;
    logic [XW-1:0]  val_q, val_d;
    logic [IDW-1:0] id_q, id_d;
    logic           fetch_q, fetch_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [31:0]    buf_q, buf_d;
    logic           sb_vld_q, sb_vld_d;
    logic [OPW-1:0] sb_op_q, sb_op_d;
    logic [XW-1:0]  sb_addr_q, sb_addr_d;
    logic [XW-1:0]  sb_val_q, sb_val_d;
    logic           data_rdy_q, data_rdy_d;
    logic [XW-1:0]  data_q, data_d;
    logic [IDW-1:0] mid_q, mid_d;
    logic           inst_rdy_q, inst_rdy_d;
    logic [31:0]    inst_q, inst_d;

    logic [2:0]     nb;
    logic [XW-1:0]  byte_a;
    logic           io_stall;
    logic [1:0]     rd_sel;
    logic [31:0]    word;

    function automatic logic [2:0] num_bytes(input logic [OPW-1:0] op, input logic fetch);
        logic [2:0] n;
        case (op)
            OP_SB, OP_LB, OP_LBU: n = 3'd1;
            OP_SH, OP_LH, OP_LHU: n = 3'd2;
            OP_SW, OP_LW:         n = 3'd4;
            default:              n = 3'd4;
        endcase
        if (fetch) n = 3'd4;
        return n;
    endfunction

    function automatic logic [XW-1:0] extend(input logic [OPW-1:0] op, input logic [31:0] w);
        logic [XW-1:0] r;
        case (op)
            OP_LB:   r = {{24{w[7]}}, w[7:0]};
            OP_LH:   r = {{16{w[15]}}, w[15:0]};
            OP_LBU:  r = {24'h0, w[7:0]};
            OP_LHU:  r = {16'h0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        nb       = num_bytes(op_q, fetch_q);
        byte_a   = addr_q + XW'(cnt_q);
        io_stall = (byte_a == IO_ADDR) && io_buffer_full;
        // cnt_q counts cycles since acceptance; the byte returned now belongs to address cnt_q-1
        rd_sel   = 2'(cnt_q - 3'd1);
        word     = buf_q;
        word[{rd_sel, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        val_d      = val_q;
        id_d       = id_q;
        fetch_d    = fetch_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        sb_vld_d   = sb_vld_q;
        sb_op_d    = sb_op_q;
        sb_addr_d  = sb_addr_q;
        sb_val_d   = sb_val_q;
        data_rdy_d = data_rdy_q;
        data_d     = data_q;
        mid_d      = mid_q;
        inst_rdy_d = inst_rdy_q;
        inst_d     = inst_q;
        if (rdy) begin
            data_rdy_d = 1'b0;
            inst_rdy_d = 1'b0;
            if (rob_mem_enable) begin
                sb_vld_d  = 1'b1;
                sb_op_d   = rob_mem_op;
                sb_addr_d = rob_mem_addr;
                sb_val_d  = rob_mem_val;
            end
            case (state_q)
                IDLE: begin
                    // a ready pulse means the requester has not yet dropped its level request
                    if (!flush && !data_rdy_q && !inst_rdy_q) begin
                        cnt_d = 3'd0;
                        buf_d = 32'h0;
                        if (sb_vld_q) begin
                            state_d  = WRITE;
                            op_d     = sb_op_q;
                            addr_d   = sb_addr_q;
                            val_d    = sb_val_q;
                            fetch_d  = 1'b0;
                            sb_vld_d = rob_mem_enable;
                        end else if (lsb_load_enable) begin
                            state_d = READ;
                            op_d    = lsb_load_op;
                            addr_d  = lsb_load_addr;
                            id_d    = lsb_load_id;
                            fetch_d = 1'b0;
                        end else if (if_enable) begin
                            state_d = READ;
                            addr_d  = if_addr;
                            fetch_d = 1'b1;
                        end
                    end
                end
                READ: begin
                    if (flush) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        if (cnt_q != 3'd0) buf_d = word;
                        if (cnt_q == nb) begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                            if (fetch_q) begin
                                inst_rdy_d = 1'b1;
                                inst_d     = word;
                            end else begin
                                data_rdy_d = 1'b1;
                                data_d     = extend(op_q, word);
                                mid_d      = id_q;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    if (!io_stall) begin
                        if (cnt_q == nb - 3'd1) begin
                            state_d = IDLE;
                            cnt_d   = 3'd0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            val_q      <= '0;
            id_q       <= '0;
            fetch_q    <= 1'b0;
            cnt_q      <= 3'd0;
            buf_q      <= 32'h0;
            sb_vld_q   <= 1'b0;
            sb_op_q    <= '0;
            sb_addr_q  <= '0;
            sb_val_q   <= '0;
            data_rdy_q <= 1'b0;
            data_q     <= '0;
            mid_q      <= '0;
            inst_rdy_q <= 1'b0;
            inst_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            val_q      <= val_d;
            id_q       <= id_d;
            fetch_q    <= fetch_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            sb_vld_q   <= sb_vld_d;
            sb_op_q    <= sb_op_d;
            sb_addr_q  <= sb_addr_d;
            sb_val_q   <= sb_val_d;
            data_rdy_q <= data_rdy_d;
            data_q     <= data_d;
            mid_q      <= mid_d;
            inst_rdy_q <= inst_rdy_d;
            inst_q     <= inst_d;
        end
    end

    assign mem_wr         = rdy && (state_q == WRITE) && !io_stall;
    assign mem_a          = ((state_q == WRITE) || ((state_q == READ) && (cnt_q < nb))) ? byte_a : '0;
    assign mem_dout       = (state_q == WRITE) ? val_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    assign mem_busy       = rob_mem_enable || sb_vld_q || (state_q == WRITE);
    assign mem_data_ready = data_rdy_q;
    assign mem_data       = data_q;
    assign mem_id         = mid_q;
    assign mem_inst_ready = inst_rdy_q;
    assign mem_inst       = inst_q;

endmodule
